// File: rtl/pat_scan_pkg.sv
// Shared types and default sizing for the pattern-scan scheduler.
package pat_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_PAT_W   = 8;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/pat_scan_sched_rr_arbiter.sv
// Round-robin pick: first asserted request at or after last_served+1, wrapping.
import pat_scan_pkg::*;

module rr_arbiter #(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last_served,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] id,
    output logic                    any
);

    localparam int ID_W = $clog2(NREQ);

    // Walk from the farthest candidate to the nearest so the nearest one wins.
    always_comb begin : pick
        int idx;
        idx = 0;
        gnt = '0;
        id  = '0;
        any = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last_served) + k) % NREQ;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                id       = ID_W'(idx);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pat_scan_sched.sv
// Scheduler/controller for one shared serial pattern-detection engine.
// Optional build macro PAT_SCAN_TIMEOUT_EN adds an idle-cycle frame timeout;
// without it a frame only ends on din_last and res_abort is tied low.
import pat_scan_pkg::*;

module pat_scan_sched #(
    parameter int NREQ    = DEF_NREQ,
    parameter int PAT_W   = DEF_PAT_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [PAT_W-1:0]             cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
    input  logic                         cfg_overlap,
    input  logic [NREQ-1:0]              req,
    output logic [NREQ-1:0]              gnt,
    input  logic                         din_valid,
    input  logic                         din,
    input  logic                         din_last,
    output logic                         din_ready,
    output logic                         match_pulse,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [$clog2(NREQ)-1:0]      res_id,
    output logic [CNT_W-1:0]             res_count,
    output logic                         res_abort
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int LEN_W = $clog2(PAT_W+1);
    localparam logic [LEN_W-1:0] FULL    = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        return (l > FULL) ? FULL : l;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    state_t            state;
    logic [ID_W-1:0]   last_served;
    logic [ID_W-1:0]   cur_id;
    logic [PAT_W-1:0]  hist;
    logic [PAT_W-1:0]  pat_l;
    logic [LEN_W-1:0]  len_l;
    logic              ovl_l;
    logic [LEN_W-1:0]  fill;
    logic [CNT_W-1:0]  count;

    logic [NREQ-1:0]   arb_gnt;
    logic [ID_W-1:0]   arb_id;
    logic              arb_any;

    logic              accept;
    logic [PAT_W-1:0]  hist_nxt;
    logic [LEN_W-1:0]  fill_nxt;
    logic [PAT_W-1:0]  mask;
    logic              hit;
    logic [CNT_W-1:0]  cnt_nxt;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req         (req),
        .last_served (last_served),
        .gnt         (arb_gnt),
        .id          (arb_id),
        .any         (arb_any)
    );

    // Next history/fill for an accepted bit and the match decision on it.
    always_comb begin
        accept   = din_valid & din_ready;
        hist_nxt = PAT_W'({hist, din});
        fill_nxt = (fill >= FULL) ? fill : fill + 1'b1;
        mask     = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len_l));
        end
        hit     = (len_l != '0) && (fill_nxt >= len_l) &&
                  (((hist_nxt ^ pat_l) & mask) == '0);
        cnt_nxt = hit ? sat_inc(count) : count;
    end

`ifdef PAT_SCAN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT+1);
    logic [TO_W-1:0] idle_cnt;
    logic            timeout_hit;

    assign timeout_hit = !accept && (idle_cnt == TO_W'(TIMEOUT-1));

    // Consecutive SCAN cycles without an accepted bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (state != SCAN || accept) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign res_abort = 1'b0;
`endif

    // Frame FSM: grant, scan, hold the result until consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_served <= ID_W'(NREQ-1);
            cur_id      <= '0;
            gnt         <= '0;
            din_ready   <= 1'b0;
            match_pulse <= 1'b0;
            res_valid   <= 1'b0;
            res_id      <= '0;
            res_count   <= '0;
            hist        <= '0;
            fill        <= '0;
            count       <= '0;
            pat_l       <= '0;
            len_l       <= '0;
            ovl_l       <= 1'b0;
`ifdef PAT_SCAN_TIMEOUT_EN
            res_abort   <= 1'b0;
`endif
        end else begin
            match_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        gnt       <= arb_gnt;
                        cur_id    <= arb_id;
                        pat_l     <= cfg_pattern;
                        len_l     <= clamp_len(cfg_len);
                        ovl_l     <= cfg_overlap;
                        hist      <= '0;
                        fill      <= '0;
                        count     <= '0;
                        din_ready <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (accept) begin
                        hist        <= hist_nxt;
                        fill        <= (hit && !ovl_l) ? '0 : fill_nxt;
                        count       <= cnt_nxt;
                        match_pulse <= hit;
                        if (din_last) begin
                            gnt       <= '0;
                            din_ready <= 1'b0;
                            res_valid <= 1'b1;
                            res_id    <= cur_id;
                            res_count <= cnt_nxt;
`ifdef PAT_SCAN_TIMEOUT_EN
                            res_abort <= 1'b0;
`endif
                            state     <= REPORT;
                        end
                    end
`ifdef PAT_SCAN_TIMEOUT_EN
                    else if (timeout_hit) begin
                        gnt       <= '0;
                        din_ready <= 1'b0;
                        res_valid <= 1'b1;
                        res_id    <= cur_id;
                        res_count <= count;
                        res_abort <= 1'b1;
                        state     <= REPORT;
                    end
`endif
                end
                REPORT: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        last_served <= cur_id;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pat_scan_sched.sv
// Directed bench for pat_scan_sched; a second instance with CNT_W=2 shares
// all inputs so count saturation can be observed on the same frames.
module tb_pat_scan_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic [3:0] req;
    logic       din_valid, din, din_last, res_ready;

    logic [3:0] gnt;
    logic       din_ready, match_pulse, res_valid, res_abort;
    logic [1:0] res_id;
    logic [7:0] res_count;

    logic [3:0] s_gnt;
    logic       s_din_ready, s_match_pulse, s_res_valid, s_res_abort;
    logic [1:0] s_res_id;
    logic [1:0] s_res_count;

    int n_checks = 0;
    int n_errors = 0;
    int p;

    always #5 clk = ~clk;

    pat_scan_sched #(.NREQ(4), .PAT_W(8), .CNT_W(8), .TIMEOUT(16)) u_dut (
        .clk(clk), .reset(reset), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .req(req), .gnt(gnt), .din_valid(din_valid),
        .din(din), .din_last(din_last), .din_ready(din_ready),
        .match_pulse(match_pulse), .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_count(res_count), .res_abort(res_abort)
    );

    pat_scan_sched #(.NREQ(4), .PAT_W(8), .CNT_W(2), .TIMEOUT(16)) u_sat (
        .clk(clk), .reset(reset), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .req(req), .gnt(s_gnt), .din_valid(din_valid),
        .din(din), .din_last(din_last), .din_ready(s_din_ready),
        .match_pulse(s_match_pulse), .res_valid(s_res_valid), .res_ready(res_ready),
        .res_id(s_res_id), .res_count(s_res_count), .res_abort(s_res_abort)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed n bits, LSB of bits first, din_last on the final one; count pulses.
    task automatic run_frame(input logic [31:0] bits, input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            din_valid = 1'b1;
            din       = bits[i];
            din_last  = (i == n - 1);
            tick();
            if (match_pulse === 1'b1) pulses++;
        end
        din_valid = 1'b0;
        din       = 1'b0;
        din_last  = 1'b0;
    endtask

    task automatic release_result(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_rv_clr"}, res_valid, 0);
        check({tag, "_gnt_idle"}, gnt, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        req = '0; din_valid = 1'b0; din = 1'b0; din_last = 1'b0; res_ready = 1'b0;
        tick(); tick();
        check("rst_gnt", gnt, 0);
        check("rst_rdy", din_ready, 0);
        check("rst_pulse", match_pulse, 0);
        check("rst_rv", res_valid, 0);
        check("rst_id", res_id, 0);
        check("rst_cnt", res_count, 0);
        check("rst_abort", res_abort, 0);
        reset = 1'b0;
        tick();

        // 101, non-overlapping, frame 1,0,1,0,1
        cfg_pattern = 8'b101; cfg_len = 4'd3; cfg_overlap = 1'b0;
        req = 4'b0001;
        tick();
        check("a_gnt", gnt, 4'b0001);
        check("a_rdy", din_ready, 1);
        run_frame(32'b10101, 5, p);
        check("a_pulses", p, 1);
        check("a_rv", res_valid, 1);
        check("a_gnt_off", gnt, 0);
        check("a_rdy_off", din_ready, 0);
        check("a_cnt", res_count, 1);
        check("a_id", res_id, 0);
        check("a_abort", res_abort, 0);
        // hold in REPORT with req still high
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_rv", res_valid, 1);
            check("hold_cnt", res_count, 1);
            check("hold_id", res_id, 0);
            check("hold_gnt", gnt, 0);
        end
        req = 4'b0000;
        release_result("a");

        // same frame overlapping; cfg changes after grant must be ignored
        cfg_overlap = 1'b1;
        req = 4'b0001;
        tick();
        check("b_gnt", gnt, 4'b0001);
        req = 4'b0000; cfg_overlap = 1'b0; cfg_pattern = 8'hFF; cfg_len = 4'd1;
        run_frame(32'b10101, 5, p);
        check("b_pulses", p, 2);
        check("b_cnt", res_count, 2);
        release_result("b");

        // single-bit pattern, six ones: 6 on the wide counter, 3 on the 2-bit one
        cfg_pattern = 8'h01; cfg_len = 4'd1; cfg_overlap = 1'b1;
        req = 4'b0001;
        tick();
        check("c_gnt", gnt, 4'b0001);
        req = 4'b0000;
        run_frame(32'b111111, 6, p);
        check("c_pulses", p, 6);
        check("c_cnt", res_count, 6);
        check("c_sat_cnt", s_res_count, 3);
        release_result("c");

        // reset in the middle of a frame from requester 2
        req = 4'b0100;
        tick();
        check("d_gnt", gnt, 4'b0100);
        req = 4'b0000;
        din_valid = 1'b1; din = 1'b1;
        tick(); tick();
        din_valid = 1'b0; din = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("d_rst_gnt", gnt, 0);
        check("d_rst_rdy", din_ready, 0);
        check("d_rst_pulse", match_pulse, 0);
        check("d_rst_rv", res_valid, 0);
        check("d_rst_cnt", res_count, 0);
        tick();
        check("d_rst_rv2", res_valid, 0);
        reset = 1'b0;
        // after reset requester 0 wins; cfg_len=0 disables matching
        cfg_len = 4'd0; cfg_pattern = 8'h03;
        req = 4'b1111;
        tick();
        check("d_gnt0", gnt, 4'b0001);
        req = 4'b0000;
        run_frame(32'b11, 2, p);
        check("d_pulses", p, 0);
        check("d_cnt", res_count, 0);
        check("d_id", res_id, 0);
        release_result("d");

        // rotation over req=1010: ids 1,3,1; first frame also checks length clamp
        cfg_pattern = 8'hFF; cfg_len = 4'd15; cfg_overlap = 1'b1;
        req = 4'b1010;
        tick();
        check("e_gnt1", gnt, 4'b0010);
        run_frame(32'h1FF, 9, p);
        check("e_pulses", p, 2);
        check("e_cnt", res_count, 2);
        check("e_id1", res_id, 1);
        release_result("e1");
        tick();
        check("e_gnt3", gnt, 4'b1000);
        run_frame(32'b0, 1, p);
        check("e_id3", res_id, 3);
        release_result("e2");
        tick();
        check("e_gnt1b", gnt, 4'b0010);
        run_frame(32'b0, 1, p);
        check("e_id1b", res_id, 1);
        req = 4'b0000;
        release_result("e3");

        // idle stretch inside a frame
        req = 4'b0001;
        tick();
        check("f_gnt", gnt, 4'b0001);
        req = 4'b0000;
        for (int i = 0; i < 15; i++) tick();
        check("f_rv15", res_valid, 0);
`ifdef PAT_SCAN_TIMEOUT_EN
        tick();
        check("f_to_rv", res_valid, 1);
        check("f_to_abort", res_abort, 1);
        check("f_to_cnt", res_count, 0);
        check("f_to_gnt", gnt, 0);
        release_result("f");
`else
        for (int i = 0; i < 5; i++) tick();
        check("f_rv20", res_valid, 0);
        check("f_rdy20", din_ready, 1);
        run_frame(32'b0, 1, p);
        check("f_rv_end", res_valid, 1);
        check("f_abort", res_abort, 0);
        release_result("f");
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pat_scan_sched.md
# pat_scan_sched

Round-robin scheduler and controller for one shared serial pattern-detection engine. Up to NREQ requesters each submit a framed serial bit stream. The block grants the engine to one requester per frame and latches the pattern configuration at grant. It scans the frame for the configured pattern, in overlapping or non-overlapping mode, and returns a per-frame match count tagged with the requester id. It sits between the serial front-end channels and the status/CSR logic.

## Interface
- NREQ, 4, number of requesters (2..16)
- PAT_W, 8, maximum pattern length in bits
- CNT_W, 8, width of the per-frame match counter
- TIMEOUT, 16, idle-cycle limit inside a frame (used only with PAT_SCAN_TIMEOUT_EN)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cfg_pattern  in  PAT_W  pattern; bit 0 matches the most recent input bit
- cfg_len  in  $clog2(PAT_W+1)  pattern length; 0 disables matching; values > PAT_W clamp to PAT_W
- cfg_overlap  in  1  1 = overlapping detection, 0 = history cleared after each match
- req  in  NREQ  per-requester frame request, level, held until granted
- gnt  out  NREQ  one-hot grant, registered; upstream muxes din/din_valid/din_last by gnt
- din_valid  in  1  serial bit valid
- din  in  1  serial data bit
- din_last  in  1  marks final bit of the frame
- din_ready  out  1  engine accepts a bit this cycle
- match_pulse  out  1  one-cycle pulse per detected match
- res_valid  out  1  frame result valid
- res_ready  in  1  result consumer ready
- res_id  out  $clog2(NREQ)  id of the requester whose frame produced the result
- res_count  out  CNT_W  matches in frame, saturating
- res_abort  out  1  frame ended by timeout (constant 0 without the macro)

## Operation
- FSM states: IDLE, SCAN, REPORT.
- IDLE, any req:
  - grant the first asserted requester at or after last_served+1, modulo NREQ.
  - Register gnt, latch cfg_pattern/cfg_len/cfg_overlap, clear history and count, enter SCAN.
- SCAN:
  - din_ready=1. An accepted bit (din_valid & din_ready) shifts into history hist[PAT_W-1:0] and increments the fill counter, which saturates at PAT_W.
  - Match condition: fill >= cfg_len and hist[cfg_len-1:0] == cfg_pattern[cfg_len-1:0], evaluated on the updated history.
  - On match: count++ (saturates at 2^CNT_W-1); match_pulse fires; if cfg_overlap=0, fill clears to 0.
  - Accepted bit with din_last: enter REPORT. A match on the last bit is counted.
- REPORT:
  - gnt=0, din_ready=0, res_valid=1; res_id, res_count and res_abort are stable while res_valid=1.
  - On res_ready: update last_served to the granted id, enter IDLE.
- cfg_* changes after grant have no effect on the current frame. Deasserting req mid-frame has no effect; the frame runs to din_last.
- Reset values: gnt=0, din_ready=0, match_pulse=0, res_valid=0, res_id=0, res_count=0, res_abort=0. Reset also sets state=IDLE, last_served=NREQ-1 (so requester 0 wins first), and clears history, fill and count.
- Reset mid-frame: the frame is dropped and no result is issued.

## Timing
- req seen in IDLE at cycle N: gnt and din_ready high at N+1.
- Completing bit accepted at cycle N: match_pulse high at N+1 for exactly one cycle.
- din_last accepted at N: res_valid at N+1, gnt and din_ready low at N+1.
- res_valid & res_ready at N: IDLE at N+1; the next grant is earliest at N+2.
- Back-to-back frames from the same requester are allowed: the requester re-asserts req and arbitration still rotates.

## Configuration
- PAT_SCAN_TIMEOUT_EN defined:
  - A counter in SCAN counts consecutive cycles without an accepted bit.
  - Reaching TIMEOUT ends the frame: enter REPORT with res_abort=1 and the count so far.
- PAT_SCAN_TIMEOUT_EN undefined:
  - No timeout counter; the frame only ends on din_last; res_abort is tied to 0.

## Structure
- Shared package pat_scan_pkg: state enum (IDLE, SCAN, REPORT, logic [1:0]) and default parameter constants.
- One sub-module, rr_arbiter: NREQ-wide round-robin pick, given req and last_served, returning a one-hot grant and an id.
- Top-level module holds the FSM, history, match logic and counters.

## Test plan
- pattern=3'b101, cfg_len=3, overlap=0, frame bits 1,0,1,0,1 (last on 5th) -> match_pulse once, res_count=1.
- Same frame with overlap=1 -> two match_pulses, res_count=2.
- req=4'b1010 after reset -> grant id1 frame, then id3, then id1; res_id sequence 1,3,1.
- CNT_W=2, pattern 1'b1, cfg_len=1, frame of 6 ones -> res_count=3 (saturated).
- Reset asserted mid-SCAN -> all outputs 0 next cycle, no res_valid; the next grant goes to id0.
- res_ready held low 5 cycles in REPORT -> res_valid, res_id and res_count stable; no new gnt. With PAT_SCAN_TIMEOUT_EN: 16 idle cycles in SCAN -> res_abort=1.
